// File: rtl/sync_debounce_edge_pkg.sv
// Edge-select codes and debounce FSM state type for the debounce/edge-counter block.
// Constants only; no timing or flow control of its own.
package sync_debounce_edge_pkg;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_BOTH = 2;

    typedef enum logic [1:0] {
        S_LO      = 2'd0,
        S_PEND_HI = 2'd1,
        S_HI      = 2'd2,
        S_PEND_LO = 2'd3
    } deb_state_t;

    function automatic int dcnt_width(input int ndeb);
        return $clog2(ndeb + 1);
    endfunction

endpackage

// File: rtl/sync_event_ctr.sv
// Saturating event counter with sticky overflow and atomic snapshot-and-clear.
// Latency: count updates on the event edge, snapshot outputs one clock after snap; no backpressure.
module sync_event_ctr #(
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            evt,
    input  logic            snap,
    output logic            snap_valid,
    output logic [CNTW-1:0] snap_cnt,
    output logic            snap_ovf
);

    logic [CNTW-1:0] ecnt;
    logic [CNTW-1:0] ecnt_nxt;
    logic            ovf;
    logic            ovf_nxt;
    logic            sat;

    // A same-cycle event is folded into the snapshot so it is neither lost nor counted twice.
    assign sat      = &ecnt;
    assign ecnt_nxt = (evt && !sat) ? ecnt + 1'b1 : ecnt;
    assign ovf_nxt  = ovf | (evt & sat);

    always_ff @(posedge clk) begin
        if (reset) begin
            ecnt       <= '0;
            ovf        <= 1'b0;
            snap_valid <= 1'b0;
            snap_cnt   <= '0;
            snap_ovf   <= 1'b0;
        end else begin
            snap_valid <= snap;
            if (snap) begin
                snap_cnt <= ecnt_nxt;
                snap_ovf <= ovf_nxt;
                ecnt     <= '0;
                ovf      <= 1'b0;
            end else begin
                ecnt <= ecnt_nxt;
                ovf  <= ovf_nxt;
            end
        end
    end

endmodule

// File: rtl/sync_debounce_edge.sv
// Debounces a synchronized level, emits edge strobes and counts selected edges.
// Latency: out/rise/fall NDEB clocks after the first new sample; no backpressure.
module sync_debounce_edge
    import sync_debounce_edge_pkg::*;
#(
    parameter int NDEB = 4,
    parameter int CNTW = 16,
    parameter int EDGE = EDGE_RISE,
    parameter bit INIT = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in,
    output logic            out,
    output logic            rise,
    output logic            fall,
    input  logic            snap,
    output logic            snap_valid,
    output logic [CNTW-1:0] snap_cnt,
    output logic            snap_ovf
);

    localparam int            DW    = dcnt_width(NDEB);
    localparam logic [DW-1:0] DLAST = DW'(NDEB - 1);

    deb_state_t    state;
    logic [DW-1:0] dcnt;
    logic          rise_nxt;
    logic          fall_nxt;
    logic          evt;

    // Strobes are decoded ahead of the register so the counter moves on the same edge.
    assign rise_nxt = in && (((state == S_LO) && (NDEB == 1)) ||
                             ((state == S_PEND_HI) && (dcnt == DLAST)));
    assign fall_nxt = !in && (((state == S_HI) && (NDEB == 1)) ||
                              ((state == S_PEND_LO) && (dcnt == DLAST)));

    always_comb begin
        evt = 1'b0;
        case (EDGE)
            EDGE_RISE: evt = rise_nxt;
            EDGE_FALL: evt = fall_nxt;
            default:   evt = rise_nxt | fall_nxt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= INIT ? S_HI : S_LO;
            out   <= INIT;
            rise  <= 1'b0;
            fall  <= 1'b0;
            dcnt  <= '0;
        end else begin
            rise <= rise_nxt;
            fall <= fall_nxt;
            case (state)
                S_LO: begin
                    if (rise_nxt) begin
                        state <= S_HI;
                        out   <= 1'b1;
                        dcnt  <= '0;
                    end else if (in) begin
                        state <= S_PEND_HI;
                        dcnt  <= DW'(1);
                    end else begin
                        dcnt <= '0;
                    end
                end
                S_PEND_HI: begin
                    if (!in) begin
                        state <= S_LO;
                        dcnt  <= '0;
                    end else if (rise_nxt) begin
                        state <= S_HI;
                        out   <= 1'b1;
                        dcnt  <= '0;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                S_HI: begin
                    if (fall_nxt) begin
                        state <= S_LO;
                        out   <= 1'b0;
                        dcnt  <= '0;
                    end else if (!in) begin
                        state <= S_PEND_LO;
                        dcnt  <= DW'(1);
                    end else begin
                        dcnt <= '0;
                    end
                end
                default: begin
                    if (in) begin
                        state <= S_HI;
                        dcnt  <= '0;
                    end else if (fall_nxt) begin
                        state <= S_LO;
                        out   <= 1'b0;
                        dcnt  <= '0;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
            endcase
        end
    end

    sync_event_ctr #(
        .CNTW(CNTW)
    ) u_ctr (
        .clk       (clk),
        .reset     (reset),
        .evt       (evt),
        .snap      (snap),
        .snap_valid(snap_valid),
        .snap_cnt  (snap_cnt),
        .snap_ovf  (snap_ovf)
    );

endmodule

// File: tb/tb_sync_debounce_edge.sv
// Bench for sync_debounce_edge: vector table, corner sequences and randomized run vs a reference model.
// Four instances with different parameters share the same stimulus.
module tb_sync_debounce_edge;
    import sync_debounce_edge_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1;
    logic in    = 1'b0;
    logic snap  = 1'b0;

    logic [3:0]  o_out, o_rise, o_fall, o_sv, o_ovf;
    logic [15:0] o_cnt0, o_cnt1;
    logic [2:0]  o_cnt2;
    logic [3:0]  o_cnt3;
    logic [15:0] cnt_a [4];

    assign cnt_a[0] = o_cnt0;
    assign cnt_a[1] = o_cnt1;
    assign cnt_a[2] = {13'd0, o_cnt2};
    assign cnt_a[3] = {12'd0, o_cnt3};

    sync_debounce_edge #(.NDEB(4), .CNTW(16), .EDGE(EDGE_RISE), .INIT(1'b0)) u0 (
        .clk(clk), .reset(reset), .in(in), .out(o_out[0]), .rise(o_rise[0]), .fall(o_fall[0]),
        .snap(snap), .snap_valid(o_sv[0]), .snap_cnt(o_cnt0), .snap_ovf(o_ovf[0]));
    sync_debounce_edge #(.NDEB(4), .CNTW(16), .EDGE(EDGE_BOTH), .INIT(1'b0)) u1 (
        .clk(clk), .reset(reset), .in(in), .out(o_out[1]), .rise(o_rise[1]), .fall(o_fall[1]),
        .snap(snap), .snap_valid(o_sv[1]), .snap_cnt(o_cnt1), .snap_ovf(o_ovf[1]));
    sync_debounce_edge #(.NDEB(4), .CNTW(3), .EDGE(EDGE_RISE), .INIT(1'b0)) u2 (
        .clk(clk), .reset(reset), .in(in), .out(o_out[2]), .rise(o_rise[2]), .fall(o_fall[2]),
        .snap(snap), .snap_valid(o_sv[2]), .snap_cnt(o_cnt2), .snap_ovf(o_ovf[2]));
    sync_debounce_edge #(.NDEB(1), .CNTW(4), .EDGE(EDGE_FALL), .INIT(1'b1)) u3 (
        .clk(clk), .reset(reset), .in(in), .out(o_out[3]), .rise(o_rise[3]), .fall(o_fall[3]),
        .snap(snap), .snap_valid(o_sv[3]), .snap_cnt(o_cnt3), .snap_ovf(o_ovf[3]));

    int n_chk  = 0;
    int n_pass = 0;

    function automatic int p_ndeb(input int k);
        return (k == 3) ? 1 : 4;
    endfunction
    function automatic int p_cntw(input int k);
        case (k)
            2:       return 3;
            3:       return 4;
            default: return 16;
        endcase
    endfunction
    function automatic int p_edge(input int k);
        case (k)
            1:       return EDGE_BOTH;
            3:       return EDGE_FALL;
            default: return EDGE_RISE;
        endcase
    endfunction
    function automatic bit p_init(input int k);
        return (k == 3);
    endfunction

    // Reference model: level flips once the last NDEB samples since reset/last flip all disagree with it;
    // edges are tallied as an unbounded integer and clipped only when a snapshot is taken.
    bit          m_out  [4];
    bit          m_rise [4];
    bit          m_fall [4];
    bit          m_sv   [4];
    bit          m_sovf [4];
    longint      m_scnt [4];
    longint      m_count[4];
    int          m_nsamp[4];
    logic [31:0] m_hist [4];

    task automatic model_update(input logic i_in, input logic i_snap, input logic i_rst);
        for (int k = 0; k < 4; k++) begin
            longint      maxv;
            logic [31:0] mask;
            bit          counted;
            maxv = (64'd1 << p_cntw(k)) - 1;
            mask = (32'd1 << p_ndeb(k)) - 1;
            m_rise[k] = 1'b0;
            m_fall[k] = 1'b0;
            if (i_rst) begin
                m_out[k]   = p_init(k);
                m_sv[k]    = 1'b0;
                m_sovf[k]  = 1'b0;
                m_scnt[k]  = 0;
                m_count[k] = 0;
                m_nsamp[k] = 0;
                m_hist[k]  = '0;
            end else begin
                m_hist[k]  = {m_hist[k][30:0], i_in};
                m_nsamp[k] = m_nsamp[k] + 1;
                if (m_nsamp[k] >= p_ndeb(k) &&
                    (m_hist[k] & mask) == (m_out[k] ? 32'd0 : mask)) begin
                    m_out[k]   = !m_out[k];
                    m_rise[k]  = m_out[k];
                    m_fall[k]  = !m_out[k];
                    m_nsamp[k] = 0;
                end
                counted = (p_edge(k) == EDGE_RISE && m_rise[k]) ||
                          (p_edge(k) == EDGE_FALL && m_fall[k]) ||
                          (p_edge(k) == EDGE_BOTH && (m_rise[k] || m_fall[k]));
                if (counted) m_count[k] = m_count[k] + 1;
                m_sv[k] = i_snap;
                if (i_snap) begin
                    m_scnt[k]  = (m_count[k] > maxv) ? maxv : m_count[k];
                    m_sovf[k]  = (m_count[k] > maxv);
                    m_count[k] = 0;
                end
            end
        end
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // One clock: drive, clock, sample 1 time unit after the edge, compare every instance to the model.
    task automatic step(input logic i_in, input logic i_snap, input logic i_rst);
        logic [20:0] act, exp;
        in    = i_in;
        snap  = i_snap;
        reset = i_rst;
        @(posedge clk);
        #1;
        model_update(i_in, i_snap, i_rst);
        for (int k = 0; k < 4; k++) begin
            act = {o_out[k], o_rise[k], o_fall[k], o_sv[k], o_ovf[k], cnt_a[k]};
            exp = {m_out[k], m_rise[k], m_fall[k], m_sv[k], m_sovf[k], m_scnt[k][15:0]};
            chk($sformatf("model u%0d t=%0t", k, $time), longint'(act), longint'(exp));
        end
    endtask

    task automatic pulses(input int n, input int hi, input int lo);
        for (int p = 0; p < n; p++) begin
            for (int j = 0; j < hi; j++) step(1'b1, 1'b0, 1'b0);
            for (int j = 0; j < lo; j++) step(1'b0, 1'b0, 1'b0);
        end
    endtask

    typedef struct {
        logic        i_in, i_snap, i_rst;
        logic        e_out, e_rise, e_fall, e_sv, e_ovf;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic addv(input int n, input logic i_in, input logic i_snap, input logic i_rst,
                        input logic e_out, input logic e_rise, input logic e_fall,
                        input logic e_sv, input logic [15:0] e_cnt, input logic e_ovf);
        vec_t v;
        v.i_in = i_in;   v.i_snap = i_snap; v.i_rst = i_rst;
        v.e_out = e_out; v.e_rise = e_rise; v.e_fall = e_fall;
        v.e_sv = e_sv;   v.e_cnt = e_cnt;   v.e_ovf = e_ovf;
        for (int j = 0; j < n; j++) tbl.push_back(v);
    endtask

    initial begin
        logic cur;

        // Expectations for u0: NDEB=4, rising edges counted, 16-bit counter, INIT=0.
        //   n  in snap rst  out rise fall sv  cnt  ovf
        addv(2, 0, 0, 1,     0, 0, 0, 0,  0, 0);
        addv(3, 0, 0, 0,     0, 0, 0, 0,  0, 0);
        addv(1, 0, 1, 0,     0, 0, 0, 1,  0, 0);
        addv(1, 0, 0, 0,     0, 0, 0, 0,  0, 0);
        addv(3, 1, 0, 0,     0, 0, 0, 0,  0, 0);
        addv(1, 0, 0, 0,     0, 0, 0, 0,  0, 0);
        addv(3, 1, 0, 0,     0, 0, 0, 0,  0, 0);
        addv(1, 1, 0, 0,     1, 1, 0, 0,  0, 0);
        addv(1, 1, 0, 0,     1, 0, 0, 0,  0, 0);
        addv(1, 1, 1, 0,     1, 0, 0, 1,  1, 0);
        addv(1, 1, 0, 0,     1, 0, 0, 0,  1, 0);
        addv(3, 0, 0, 0,     1, 0, 0, 0,  1, 0);
        addv(1, 0, 0, 0,     0, 0, 1, 0,  1, 0);
        addv(1, 0, 0, 0,     0, 0, 0, 0,  1, 0);
        addv(3, 1, 0, 0,     0, 0, 0, 0,  1, 0);
        addv(1, 1, 0, 1,     0, 0, 0, 0,  0, 0);
        addv(3, 1, 0, 0,     0, 0, 0, 0,  0, 0);
        addv(1, 1, 0, 0,     1, 1, 0, 0,  0, 0);
        addv(1, 1, 0, 0,     1, 0, 0, 0,  0, 0);

        foreach (tbl[j]) begin
            step(tbl[j].i_in, tbl[j].i_snap, tbl[j].i_rst);
            chk($sformatf("vec%0d", j),
                longint'({o_out[0], o_rise[0], o_fall[0], o_sv[0], o_ovf[0], o_cnt0}),
                longint'({tbl[j].e_out, tbl[j].e_rise, tbl[j].e_fall, tbl[j].e_sv,
                          tbl[j].e_ovf, tbl[j].e_cnt}));
        end

        // Five clean pulses counted on both edges.
        step(1'b0, 1'b0, 1'b1);
        pulses(5, 6, 6);
        step(1'b0, 1'b1, 1'b0);
        chk("both_sv", o_sv[1], 1);
        chk("both_cnt", o_cnt1, 10);
        chk("both_ovf", o_ovf[1], 0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("both_cnt_cleared", o_cnt1, 0);

        // Snapshot landing on the same edge as the 8th counted rise.
        step(1'b0, 1'b0, 1'b1);
        pulses(7, 6, 6);
        for (int j = 0; j < 3; j++) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("same_cycle_rise", o_rise[0], 1);
        chk("same_cycle_sv", o_sv[0], 1);
        chk("same_cycle_cnt", o_cnt0, 8);
        step(1'b1, 1'b1, 1'b0);
        chk("back_to_back_cnt", o_cnt0, 0);
        chk("back_to_back_sv", o_sv[0], 1);
        for (int j = 0; j < 6; j++) step(1'b0, 1'b0, 1'b0);
        for (int j = 0; j < 4; j++) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("after_clear_cnt", o_cnt0, 1);

        // Saturation and sticky overflow on the 3-bit counter.
        step(1'b0, 1'b0, 1'b1);
        pulses(9, 6, 6);
        step(1'b0, 1'b1, 1'b0);
        chk("sat_cnt", o_cnt2, 7);
        chk("sat_ovf", o_ovf[2], 1);
        chk("wide_cnt", o_cnt0, 9);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("sat_cleared_cnt", o_cnt2, 0);
        chk("sat_cleared_ovf", o_ovf[2], 0);

        // Randomized run: short and long runs, occasional snaps and resets.
        cur = 1'b0;
        for (int j = 0; j < 3000; j++) begin
            if ($urandom_range(0, 3) == 0) cur = !cur;
            step(cur, ($urandom_range(0, 7) == 0), ($urandom_range(0, 199) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
